// File: rtl/cook_timer.sv
// cook_timer: microwave cook-time countdown.
//
// Keypad digits shift into an mm:ss BCD register. The register counts down
// once per second while the magnetron is on and pauses while it is off.
// timer_done flags 00:00 and is used downstream as a magnetron reset term.
//
// Optional build macro COOK_TIMER_BEEP_EN: when defined, an end-of-cook beep
// lasting BEEP_SECS seconds is generated. When undefined, beep is tied low
// and no beep counter exists.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_ENTRY | keypad accepted, count idle (beep may run)
// ST_COUNT | prescaler running, decrement on each tick
// ST_HOLD  | paused with time remaining, prescaler frozen
module cook_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_SECS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clearn,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       running,
  output logic       beep
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [3:0]    mt_nx, mo_nx, st_nx, so_nx;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic          count_zero;
  logic          nx_zero;

`ifdef COOK_TIMER_BEEP_EN
  localparam int BW = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;
  logic          beep_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = (BEEP_SECS > 0);
  assign beep = 1'b0;
`endif

  assign count_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'd0);
  assign nx_zero    = ({mt_nx, mo_nx, st_nx, so_nx} == 16'd0);

  // One-second BCD decrement of the current count, borrowing mm:ss style.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_so = 4'd9;
      if (sec_tens == 4'd0) begin
        dec_st = 4'd5;
        if (min_ones == 4'd0) begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end else begin
          dec_mo = min_ones - 4'd1;
        end
      end else begin
        dec_st = sec_tens - 4'd1;
      end
    end
  end

  // Next-state, prescaler, digit and beep update; clear beats everything.
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    mt_nx    = min_tens;
    mo_nx    = min_ones;
    st_nx    = sec_tens;
    so_nx    = sec_ones;
`ifdef COOK_TIMER_BEEP_EN
    beep_nx  = beep;
    bcnt_nx  = bcnt;
`endif
    if (!clearn) begin
      state_nx = ST_ENTRY;
      presc_nx = '0;
      mt_nx    = 4'd0;
      mo_nx    = 4'd0;
      st_nx    = 4'd0;
      so_nx    = 4'd0;
`ifdef COOK_TIMER_BEEP_EN
      beep_nx  = 1'b0;
`endif
    end else begin
      case (state)
        ST_ENTRY: begin
`ifdef COOK_TIMER_BEEP_EN
          // the prescaler free-runs only to time the beep
          if (beep) begin
            if (presc == PRESC_MAX) begin
              presc_nx = '0;
              bcnt_nx  = bcnt - BW'(1);
              if (bcnt <= BW'(1)) beep_nx = 1'b0;
            end else begin
              presc_nx = presc + PW'(1);
            end
          end
`endif
          if (digit_valid && (digit <= 4'd9)) begin
            mt_nx = min_ones;
            mo_nx = sec_tens;
            st_nx = sec_ones;
            so_nx = digit;
`ifdef COOK_TIMER_BEEP_EN
            beep_nx = 1'b0;
`endif
          end
          if (mag_on && !count_zero) begin
            state_nx = ST_COUNT;
            presc_nx = '0;
`ifdef COOK_TIMER_BEEP_EN
            beep_nx  = 1'b0;
`endif
          end
        end
        ST_COUNT: begin
          if (presc == PRESC_MAX) begin
            presc_nx = '0;
            if (!count_zero) begin
              mt_nx = dec_mt;
              mo_nx = dec_mo;
              st_nx = dec_st;
              so_nx = dec_so;
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
          if (nx_zero) begin
            state_nx = ST_ENTRY;
`ifdef COOK_TIMER_BEEP_EN
            beep_nx  = 1'b1;
            bcnt_nx  = BW'(BEEP_SECS);
`endif
          end else if (!mag_on) begin
            state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mag_on) state_nx = ST_COUNT;
        end
        default: begin
          state_nx = ST_ENTRY;
        end
      endcase
    end
  end

  // State and output registers; flags are registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ENTRY;
      presc      <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b1;
      running    <= 1'b0;
`ifdef COOK_TIMER_BEEP_EN
      beep       <= 1'b0;
      bcnt       <= '0;
`endif
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      min_tens   <= mt_nx;
      min_ones   <= mo_nx;
      sec_tens   <= st_nx;
      sec_ones   <= so_nx;
      timer_done <= nx_zero;
      running    <= (state_nx == ST_COUNT);
`ifdef COOK_TIMER_BEEP_EN
      beep       <= beep_nx;
      bcnt       <= bcnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Testbench for cook_timer: directed steps from the test plan followed by
// randomized stimulus, all checked against a seconds-level reference model.
module tb_cook_timer;

  localparam int T  = 4;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       clearn = 1'b1;
  logic       mag_on = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, running, beep;

  always #5 clk = ~clk;

  cook_timer #(.TICKS_PER_SEC(T), .BEEP_SECS(BS)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .clearn(clearn), .mag_on(mag_on),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .running(running), .beep(beep)
  );

  int vecs = 0;
  int errs = 0;

  // reference model: digits as mm:ss decimal fields, mode 0=entry 1=count 2=hold
  int m_d[4];
  int m_mode;
  int m_p;
  bit m_beep;
  int m_brem;

`ifdef COOK_TIMER_BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_zero();
    return (m_d[0] == 0) && (m_d[1] == 0) && (m_d[2] == 0) && (m_d[3] == 0);
  endfunction

  task automatic m_dec();
    int mm, ss;
    mm = m_d[0] * 10 + m_d[1];
    ss = m_d[2] * 10 + m_d[3];
    if (ss > 0) ss--;
    else begin
      ss = 59;
      mm--;
    end
    m_d[0] = mm / 10;
    m_d[1] = mm % 10;
    m_d[2] = ss / 10;
    m_d[3] = ss % 10;
  endtask

  task automatic model_step();
    bit go;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_d[i] = 0;
      m_mode = 0; m_p = 0; m_beep = 0; m_brem = 0;
    end else if (!clearn) begin
      for (int i = 0; i < 4; i++) m_d[i] = 0;
      m_mode = 0; m_p = 0; m_beep = 0;
    end else begin
      case (m_mode)
        0: begin
          go = mag_on && !m_zero();
          if (m_beep) begin
            m_brem--;
            if (m_brem == 0) m_beep = 0;
          end
          if (digit_valid && digit <= 9) begin
            m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = m_d[3]; m_d[3] = int'(digit);
            m_beep = 0;
          end
          if (go) begin
            m_mode = 1; m_p = 0; m_beep = 0;
          end
        end
        1: begin
          if (m_p == T - 1) begin
            m_p = 0;
            m_dec();
            if (m_zero()) begin
              m_mode = 0;
              if (BEEP_ON) begin
                m_beep = 1;
                m_brem = BS * T;
              end
            end
          end else begin
            m_p++;
          end
          if (m_mode == 1 && !mag_on) m_mode = 2;
        end
        default: if (mag_on) m_mode = 1;
      endcase
    end
  endtask

  task automatic check_all();
    chk("min_tens", int'(min_tens), m_d[0]);
    chk("min_ones", int'(min_ones), m_d[1]);
    chk("sec_tens", int'(sec_tens), m_d[2]);
    chk("sec_ones", int'(sec_ones), m_d[3]);
    chk("timer_done", int'(timer_done), int'(m_zero()));
    chk("running", int'(running), int'(m_mode == 1));
    chk("beep", int'(beep), int'(m_beep));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic enter(input int d);
    digit_valid = 1'b1;
    digit = d[3:0];
    cyc();
    digit_valid = 1'b0;
  endtask

  task automatic clr();
    clearn = 1'b0;
    cyc();
    clearn = 1'b1;
  endtask

  initial begin
    int bc;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
    m_mode = 0; m_p = 0; m_beep = 0; m_brem = 0;

    // reset
    cyc();
    rst = 1'b0;
    chk("rst_done", int'(timer_done), 1);
    chk("rst_sec_ones", int'(sec_ones), 0);

    // entry 01:30, invalid digit ignored
    enter(1); enter(3); enter(0);
    chk("entry_mt", int'(min_tens), 0);
    chk("entry_mo", int'(min_ones), 1);
    chk("entry_st", int'(sec_tens), 3);
    chk("entry_so", int'(sec_ones), 0);
    chk("entry_done", int'(timer_done), 0);
    enter(10);
    chk("bad_digit_st", int'(sec_tens), 3);
    chk("bad_digit_so", int'(sec_ones), 0);

    // countdown from 00:05
    clr();
    enter(5);
    mag_on = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      if (k == 5) chk("first_dec", int'(sec_ones), 4);
      if (k == 21) begin
        chk("expire_so", int'(sec_ones), 0);
        chk("expire_done", int'(timer_done), 1);
        chk("expire_running", int'(running), 0);
      end
    end
    run(6);
    chk("after_expire_so", int'(sec_ones), 0);

    // borrow cases
    mag_on = 1'b0;
    clr();
    enter(1); enter(0); enter(0);
    mag_on = 1'b1;
    run(5);
    chk("b0100_mo", int'(min_ones), 0);
    chk("b0100_st", int'(sec_tens), 5);
    chk("b0100_so", int'(sec_ones), 9);
    mag_on = 1'b0;
    clr();
    enter(1); enter(0); enter(0); enter(0);
    mag_on = 1'b1;
    run(5);
    chk("b1000_mt", int'(min_tens), 0);
    chk("b1000_mo", int'(min_ones), 9);
    chk("b1000_st", int'(sec_tens), 5);
    chk("b1000_so", int'(sec_ones), 9);
    mag_on = 1'b0;
    clr();
    enter(1); enter(0);
    mag_on = 1'b1;
    run(5);
    chk("b0010_st", int'(sec_tens), 0);
    chk("b0010_so", int'(sec_ones), 9);
    mag_on = 1'b0;
    clr();

    // pause and resume
    enter(4);
    mag_on = 1'b1;
    run(5);
    chk("pause_pre_so", int'(sec_ones), 3);
    run(2);
    mag_on = 1'b0;
    cyc();
    chk("hold_running", int'(running), 0);
    enter(7);
    cyc();
    chk("hold_st", int'(sec_tens), 0);
    chk("hold_so", int'(sec_ones), 3);
    mag_on = 1'b1;
    cyc();
    chk("resume_running", int'(running), 1);
    chk("resume_so_a", int'(sec_ones), 3);
    cyc();
    chk("resume_so_b", int'(sec_ones), 2);

    // clear beats digit and tick
    run(3);
    clearn = 1'b0;
    digit_valid = 1'b1;
    digit = 4'd5;
    cyc();
    clearn = 1'b1;
    digit_valid = 1'b0;
    chk("clr_so", int'(sec_ones), 0);
    chk("clr_done", int'(timer_done), 1);
    chk("clr_running", int'(running), 0);

    // reset during count
    mag_on = 1'b0;
    enter(9);
    mag_on = 1'b1;
    run(3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mag_on = 1'b0;
    chk("rst_mid_so", int'(sec_ones), 0);
    chk("rst_mid_done", int'(timer_done), 1);
    chk("rst_mid_running", int'(running), 0);
    chk("rst_mid_beep", int'(beep), 0);

    // beep length
    clr();
    enter(1);
    mag_on = 1'b1;
    run(5);
    chk("beep_expire_so", int'(sec_ones), 0);
    bc = int'(beep);
    for (int k = 0; k < 12; k++) begin
      cyc();
      bc += int'(beep);
    end
    chk("beep_cycles", bc, BEEP_ON ? BS * T : 0);

    // beep cut short by a digit
    mag_on = 1'b0;
    enter(1);
    mag_on = 1'b1;
    run(5);
    mag_on = 1'b0;
    run(2);
    chk("beep_mid", int'(beep), BEEP_ON ? 1 : 0);
    enter(3);
    chk("beep_cut", int'(beep), 0);
    chk("beep_cut_so", int'(sec_ones), 3);

    // randomized stimulus
    clr();
    repeat (1500) begin
      rst = ($urandom_range(0, 299) == 0);
      clearn = ($urandom_range(0, 59) != 0);
      digit_valid = ($urandom_range(0, 4) == 0);
      digit = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) mag_on = ~mag_on;
      cyc();
    end

    rst = 1'b0;
    clearn = 1'b1;
    digit_valid = 1'b0;
    mag_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
# cook_timer

Microwave cook-time countdown stage, directly upstream of the magnetron control latch. Accepts BCD keypad digits into an mm:ss register, counts down once per second while the magnetron is on, and drives `timer_done`, which the magnetron control uses as a reset term. The count pauses while the magnetron is off. Digits are exported for the display driver.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 1000: clock cycles per one-second tick; must be ≥2.
- `BEEP_SECS`, default 3: length of the end-of-cook beep in seconds. Used only with `COOK_TIMER_BEEP_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit`.
- `digit`  in  4  keypad value; valid range 0–9.
- `clearn`  in  1  active-low clear; level-sensitive, sampled every cycle.
- `mag_on`  in  1  magnetron latch `Q`; enables countdown.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD count.
- `timer_done`  out  1  high when all four digits are 0.
- `running`  out  1  high in the COUNT state.
- `beep`  out  1  end-of-cook indicator.

## Operation
- States:
  - ENTRY: keypad accepted.
  - COUNT: decrementing.
  - HOLD: paused with time remaining.
- Reset value of all outputs: digits 0, `timer_done`=1, `running`=0, `beep`=0. State is ENTRY and the prescaler is 0.
- `clearn`=0 has priority over every other input in every state. It zeroes the digits, zeroes the prescaler, sets state to ENTRY, and clears `beep`.
- Digit entry happens only in ENTRY, with `digit_valid`=1 and `digit`≤9. It is a left shift: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit`.
  - Digits above 9 are ignored.
  - Strobes in COUNT or HOLD are ignored.
  - Entry does not clamp; `sec_tens` may hold up to 9.
- State transitions:
  - ENTRY→COUNT: `mag_on`=1 and count≠0. The prescaler is cleared to 0.
  - ENTRY with `mag_on`=1 and count=0: stays in ENTRY.
  - COUNT→HOLD: `mag_on`=0 and count≠0 after this cycle's update. The prescaler is frozen.
  - HOLD→COUNT: `mag_on`=1. The prescaler resumes from its held value.
  - COUNT→ENTRY: the decrement produces 00:00.
- Prescaler: counts 0..`TICKS_PER_SEC`−1 in COUNT only. A tick occurs when it equals `TICKS_PER_SEC`−1; the prescaler wraps to 0 on the tick.
- Decrement on tick, BCD with borrow:
  - `sec_ones`: 0→9 with borrow, else −1.
  - `sec_tens`: on borrow, 0→5 with borrow, else −1.
  - `min_ones`: on borrow, 0→9 with borrow, else −1.
  - `min_tens`: on borrow, −1.
  - The count never goes below 00:00.
- The tick and decrement occur in COUNT even when `mag_on` falls on the same cycle; the state then goes to HOLD, or to ENTRY if the count reached 0.
- `rst` mid-operation: the next state equals the reset state regardless of any other input.

## Timing
- Digit entry: the new digit is visible on outputs 1 cycle after the `digit_valid` cycle.
- The first decrement is visible `TICKS_PER_SEC`+1 cycles after the first cycle `mag_on`=1 is sampled in ENTRY. The ENTRY→COUNT transition takes 1 cycle; the prescaler then needs `TICKS_PER_SEC` cycles.
- Subsequent decrements occur every `TICKS_PER_SEC` cycles in COUNT.
- `timer_done`, `running`, and the digits are registered-state-derived, with no combinational path from inputs.
- `timer_done` rises in the same cycle the digits show 00:00.
- `clearn` takes effect on the next edge.

## Configuration
- `COOK_TIMER_BEEP_EN` defined:
  - `beep` rises on the cycle countdown reaches 00:00 (not on clear or reset).
  - It stays high for `BEEP_SECS`×`TICKS_PER_SEC` cycles, using the same prescaler, free-running during the beep.
  - It clears early on `clearn`=0 or on an accepted digit.
  - A new COUNT entry also clears it.
- `COOK_TIMER_BEEP_EN` undefined: `beep` is tied to 0 and the beep counter is not built.

## Test plan
Bench uses `TICKS_PER_SEC`=4 and `BEEP_SECS`=2.

1. Entry: after `rst`, strobe digits 1, 3, 0. Expected outputs 0,1,3,0 (01:30) and `timer_done`=0. Then strobe `digit`=0xA; outputs stay 01:30.
2. Countdown:
   - Enter 5 (00:05) and hold `mag_on`=1.
   - Expect 00:04 at cycle 5 after `mag_on`.
   - Expect 00:00 at cycle 21, with `timer_done`=1 and `running`=0 in that cycle.
   - No further change afterwards.
3. Borrow cases:
   - 01:00 one tick → 00:59.
   - 10:00 one tick → 09:59.
   - 00:10 one tick → 00:09.
4. Pause:
   - At 00:03 with prescaler=2, drop `mag_on`: state HOLD, digits hold, `digit_valid` ignored.
   - Raise `mag_on`: 00:02 appears after 2 more cycles in COUNT.
5. Priority:
   - `clearn`=0 in the same cycle as `digit_valid` and a tick in COUNT: digits become 00:00, state ENTRY, `timer_done`=1.
   - `rst` during COUNT gives the full reset values.
6. Beep (macro on):
   - Expiry from 00:01 raises `beep` for 8 cycles.
   - A second run where a digit is accepted 2 cycles after expiry drops `beep` on the next edge.
   - With the macro off, `beep` stays 0 throughout.
